ex_flags_branch: RTL and testbench

EX_FLAGS_BRANCH -- requirements
Module: ex_flags_branch

---
 rtl/ex_flags_branch.sv | 173 +++++++++++++++++
 tb/tb_ex_flags_branch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_flags_branch.sv
// ---------------------------------------------------------------------------
// ex_flags_branch
//
// Execute-stage condition-code register (CCR) and branch resolution unit.
//
// The CCR holds {C,N,Z}. Flags are updated from the ALU of the instruction in
// EX, from SETC/CLRC, from a taken conditional branch (the tested flag is
// consumed), and from the interrupt shadow copy on RTI. Branches are resolved
// against the registered CCR, so they see only the flags of older
// instructions.
//
// A taken branch produces a one-cycle registered br_taken pulse with br_pc,
// and starts a two-cycle flush. The instructions behind the branch are
// squashed, so every instruction input is ignored during the flush. Inputs are
// also ignored while stall is high.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-high reset
//   alu_carry    : ALU carry of the EX instruction
//   alu_zero     : ALU zero flag of the EX instruction
//   alu_neg      : ALU negative flag of the EX instruction
//   flag_we[2:0] : per-flag write enable {C,N,Z}
//   set_c/clr_c  : SETC / CLRC
//   br_type[2:0] : 000 none, 001 JZ, 010 JN, 011 JC, 100 JMP, others none
//   br_target    : branch target address
//   stall        : EX instruction is not valid this cycle
//   ccr_save     : interrupt entry, copy the CCR into the shadow register
//   ccr_restore  : RTI, copy the shadow register into the CCR
//   ccr[2:0]     : condition code register {C,N,Z}
//   br_taken     : registered branch-taken pulse
//   br_pc        : registered branch target, valid while br_taken=1
//   flush        : squash the IF/ID instructions
// ---------------------------------------------------------------------------
module ex_flags_branch #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_carry,
    input  logic         alu_zero,
    input  logic         alu_neg,
    input  logic [2:0]   flag_we,
    input  logic         set_c,
    input  logic         clr_c,
    input  logic [2:0]   br_type,
    input  logic [W-1:0] br_target,
    input  logic         stall,
    input  logic         ccr_save,
    input  logic         ccr_restore,
    output logic [2:0]   ccr,
    output logic         br_taken,
    output logic [W-1:0] br_pc,
    output logic         flush
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FL1  = 2'd1,
        FL2  = 2'd2
    } fl_state_t;

    localparam logic [2:0] BR_JMP = 3'b100;

    fl_state_t      state_reg;
    logic [2:0]     ccr_reg;
    logic [2:0]     ccr_next;
    logic [2:0]     shadow_reg;
    logic           br_taken_reg;
    logic [W-1:0]   br_pc_reg;
    logic           flush_reg;

    logic           accept;
    logic           taken;
    logic [2:0]     alu_flags;
    logic [2:0]     cond_hit;
    logic [2:0]     flag_upd;

    // The EX instruction counts only when it is neither stalled nor squashed.
    assign accept    = !stall && (state_reg == IDLE);
    assign alu_flags = {alu_carry, alu_neg, alu_zero};

    // Bit gi of the CCR is tested by branch code gi+1 (JZ=1, JN=2, JC=3).
    // Priority per flag: restore > taken-branch clear > SETC/CLRC > flag_we.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            localparam logic [2:0] BR_CODE = 3'(gi + 1);

            assign cond_hit[gi] = ccr_reg[gi] && (br_type == BR_CODE);

            if (gi == 2) begin : g_carry
                // SETC and CLRC together cancel and leave C alone, and
                // still override flag_we[2].
                always_comb begin
                    flag_upd[gi] = ccr_reg[gi];
                    if (set_c || clr_c) begin
                        if (set_c && !clr_c) begin
                            flag_upd[gi] = 1'b1;
                        end else if (clr_c && !set_c) begin
                            flag_upd[gi] = 1'b0;
                        end
                    end else if (flag_we[gi]) begin
                        flag_upd[gi] = alu_flags[gi];
                    end
                end
            end else begin : g_zn
                assign flag_upd[gi] = flag_we[gi] ? alu_flags[gi] : ccr_reg[gi];
            end

            always_comb begin
                ccr_next[gi] = ccr_reg[gi];
                if (accept) begin
                    if (ccr_restore) begin
                        ccr_next[gi] = shadow_reg[gi];
                    end else if (cond_hit[gi]) begin
                        ccr_next[gi] = 1'b0;
                    end else begin
                        ccr_next[gi] = flag_upd[gi];
                    end
                end
            end
        end
    endgenerate

    assign taken = accept && ((|cond_hit) || (br_type == BR_JMP));

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_reg      <= 3'b000;
            shadow_reg   <= 3'b000;
            br_taken_reg <= 1'b0;
            br_pc_reg    <= '0;
            state_reg    <= IDLE;
            flush_reg    <= 1'b0;
        end else begin
            ccr_reg      <= ccr_next;
            br_taken_reg <= taken;
            if (taken) begin
                br_pc_reg <= br_target;
            end
            // The shadow captures the CCR as it was before this edge's update.
            // A simultaneous restore wins and leaves the shadow alone.
            if (accept && ccr_save && !ccr_restore) begin
                shadow_reg <= ccr_reg;
            end
            // The flush counter keeps running during a stall.
            case (state_reg)
                IDLE: begin
                    if (taken) begin
                        state_reg <= FL1;
                        flush_reg <= 1'b1;
                    end else begin
                        flush_reg <= 1'b0;
                    end
                end
                FL1: begin
                    state_reg <= FL2;
                    flush_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ccr      = ccr_reg;
    assign br_taken = br_taken_reg;
    assign br_pc    = br_pc_reg;
    assign flush    = flush_reg;

endmodule

// File: tb/tb_ex_flags_branch.sv
// ---------------------------------------------------------------------------
// tb_ex_flags_branch
//
// Directed bench for ex_flags_branch. Each step drives the inputs for one
// cycle and pushes the outputs expected after the next rising edge onto a
// scoreboard queue. The entry is then popped and compared against the DUT
// one time unit after that edge.
// ---------------------------------------------------------------------------
module tb_ex_flags_branch;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         alu_carry;
    logic         alu_zero;
    logic         alu_neg;
    logic [2:0]   flag_we;
    logic         set_c;
    logic         clr_c;
    logic [2:0]   br_type;
    logic [W-1:0] br_target;
    logic         stall;
    logic         ccr_save;
    logic         ccr_restore;
    logic [2:0]   ccr;
    logic         br_taken;
    logic [W-1:0] br_pc;
    logic         flush;

    typedef struct {
        string        tag;
        logic [2:0]   ccr;
        logic         br_taken;
        logic [W-1:0] br_pc;
        logic         flush;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fails;

    ex_flags_branch #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_neg     (alu_neg),
        .flag_we     (flag_we),
        .set_c       (set_c),
        .clr_c       (clr_c),
        .br_type     (br_type),
        .br_target   (br_target),
        .stall       (stall),
        .ccr_save    (ccr_save),
        .ccr_restore (ccr_restore),
        .ccr         (ccr),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst         = 1'b0;
        alu_carry   = 1'b0;
        alu_zero    = 1'b0;
        alu_neg     = 1'b0;
        flag_we     = 3'b000;
        set_c       = 1'b0;
        clr_c       = 1'b0;
        br_type     = 3'b000;
        br_target   = '0;
        stall       = 1'b0;
        ccr_save    = 1'b0;
        ccr_restore = 1'b0;
    endtask

    // Queue the expectation, clock once, then pop and check all outputs.
    // The inputs return to idle afterwards.
    task automatic step(input string tag, input logic [2:0] e_ccr,
                        input logic e_bt, input logic [W-1:0] e_pc,
                        input logic e_flush);
        exp_t e;
        e.tag = tag; e.ccr = e_ccr; e.br_taken = e_bt; e.br_pc = e_pc; e.flush = e_flush;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        assert (ccr === e.ccr) else begin
            n_fails++;
            $error("FAIL %s ccr: observed %b expected %b", e.tag, ccr, e.ccr);
        end
        n_checks++;
        assert (br_taken === e.br_taken) else begin
            n_fails++;
            $error("FAIL %s br_taken: observed %b expected %b", e.tag, br_taken, e.br_taken);
        end
        n_checks++;
        assert (br_pc === e.br_pc) else begin
            n_fails++;
            $error("FAIL %s br_pc: observed %h expected %h", e.tag, br_pc, e.br_pc);
        end
        n_checks++;
        assert (flush === e.flush) else begin
            n_fails++;
            $error("FAIL %s flush: observed %b expected %b", e.tag, flush, e.flush);
        end
        $display("step %-16s ccr=%b br_taken=%b br_pc=%h flush=%b", e.tag, ccr, br_taken, br_pc, flush);
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_inputs();
        #2;

        // Reset
        rst = 1'b1;
        step("reset", 3'b000, 1'b0, 16'h0000, 1'b0);

        // Flag write followed by a taken JZ that consumes Z
        flag_we = 3'b111; alu_carry = 1'b1; alu_neg = 1'b0; alu_zero = 1'b1;
        step("flags_we111", 3'b101, 1'b0, 16'h0000, 1'b0);
        br_type = 3'b001; br_target = 16'h0040;
        step("jz_taken", 3'b100, 1'b1, 16'h0040, 1'b1);
        step("jz_fl2", 3'b100, 1'b0, 16'h0040, 1'b1);
        step("jz_idle", 3'b100, 1'b0, 16'h0040, 1'b0);

        // JC with C clear is not taken; SETC overrides flag_we[2]
        clr_c = 1'b1;
        step("clrc", 3'b000, 1'b0, 16'h0040, 1'b0);
        br_type = 3'b011; br_target = 16'h0099;
        step("jc_not_taken", 3'b000, 1'b0, 16'h0040, 1'b0);
        set_c = 1'b1; flag_we = 3'b100; alu_carry = 1'b0;
        step("setc_over_we", 3'b100, 1'b0, 16'h0040, 1'b0);
        set_c = 1'b1; clr_c = 1'b1; flag_we = 3'b100; alu_carry = 1'b0;
        step("setc_clrc_both", 3'b100, 1'b0, 16'h0040, 1'b0);

        // A taken JN clear beats a same-cycle N write; branches are ignored during the flush
        flag_we = 3'b111; alu_carry = 1'b0; alu_neg = 1'b1; alu_zero = 1'b0;
        step("set_n", 3'b010, 1'b0, 16'h0040, 1'b0);
        br_type = 3'b010; br_target = 16'h0123; flag_we = 3'b010; alu_neg = 1'b1;
        step("jn_clear_wins", 3'b000, 1'b1, 16'h0123, 1'b1);
        br_type = 3'b100; br_target = 16'h0555;
        flag_we = 3'b111; alu_carry = 1'b1; alu_neg = 1'b1; alu_zero = 1'b1;
        step("jmp_in_fl1", 3'b000, 1'b0, 16'h0123, 1'b1);
        br_type = 3'b100; br_target = 16'h0666; set_c = 1'b1;
        step("jmp_in_fl2", 3'b000, 1'b0, 16'h0123, 1'b0);
        br_type = 3'b100; br_target = 16'h0777;
        step("jmp_after_fl2", 3'b000, 1'b1, 16'h0777, 1'b1);
        step("jmp_fl2", 3'b000, 1'b0, 16'h0777, 1'b1);
        step("jmp_idle", 3'b000, 1'b0, 16'h0777, 1'b0);

        // Shadow save and restore
        flag_we = 3'b111; alu_carry = 1'b0; alu_neg = 1'b1; alu_zero = 1'b1;
        step("set_011", 3'b011, 1'b0, 16'h0777, 1'b0);
        ccr_save = 1'b1;
        step("save", 3'b011, 1'b0, 16'h0777, 1'b0);
        flag_we = 3'b111;
        step("clear_all", 3'b000, 1'b0, 16'h0777, 1'b0);
        ccr_restore = 1'b1; flag_we = 3'b111; alu_carry = 1'b1; alu_neg = 1'b1; alu_zero = 1'b1;
        step("restore_wins", 3'b011, 1'b0, 16'h0777, 1'b0);
        br_type = 3'b111; br_target = 16'h0fff;
        step("code111_none", 3'b011, 1'b0, 16'h0777, 1'b0);
        flag_we = 3'b111; alu_carry = 1'b1;
        step("set_100", 3'b100, 1'b0, 16'h0777, 1'b0);
        ccr_save = 1'b1; ccr_restore = 1'b1;
        step("save_restore", 3'b011, 1'b0, 16'h0777, 1'b0);
        flag_we = 3'b111; alu_carry = 1'b1;
        step("set_100_again", 3'b100, 1'b0, 16'h0777, 1'b0);
        ccr_restore = 1'b1;
        step("shadow_kept", 3'b011, 1'b0, 16'h0777, 1'b0);

        // A stall blocks branches and flag writes but not the flush counter
        stall = 1'b1; br_type = 3'b100; br_target = 16'h1234;
        flag_we = 3'b111; alu_carry = 1'b1; alu_neg = 1'b0; alu_zero = 1'b0;
        step("stall_jmp", 3'b011, 1'b0, 16'h0777, 1'b0);
        br_type = 3'b100; br_target = 16'h0200;
        step("jmp_200", 3'b011, 1'b1, 16'h0200, 1'b1);
        stall = 1'b1;
        step("stall_in_fl1", 3'b011, 1'b0, 16'h0200, 1'b1);
        step("fl2_to_idle", 3'b011, 1'b0, 16'h0200, 1'b0);

        // Reset during FL1
        br_type = 3'b100; br_target = 16'h0300;
        step("jmp_300", 3'b011, 1'b1, 16'h0300, 1'b1);
        rst = 1'b1; br_type = 3'b100; br_target = 16'h0301;
        step("rst_in_fl1", 3'b000, 1'b0, 16'h0000, 1'b0);

        // A taken JC clear beats SETC; then reset during FL2
        flag_we = 3'b100; alu_carry = 1'b1;
        step("set_c_we", 3'b100, 1'b0, 16'h0000, 1'b0);
        br_type = 3'b011; br_target = 16'h0abc; set_c = 1'b1;
        step("jc_clear_wins", 3'b000, 1'b1, 16'h0abc, 1'b1);
        step("jc_fl2", 3'b000, 1'b0, 16'h0abc, 1'b1);
        flag_we = 3'b111; alu_carry = 1'b1; alu_zero = 1'b1;
        step("jc_fl2_ignored", 3'b000, 1'b0, 16'h0abc, 1'b0);
        flag_we = 3'b111; alu_carry = 1'b1; alu_neg = 1'b1; alu_zero = 1'b1;
        step("set_111", 3'b111, 1'b0, 16'h0abc, 1'b0);
        br_type = 3'b100; br_target = 16'h0bcd;
        step("jmp_bcd", 3'b111, 1'b1, 16'h0bcd, 1'b1);
        step("jmp_bcd_fl1", 3'b111, 1'b0, 16'h0bcd, 1'b1);
        rst = 1'b1;
        step("rst_in_fl2", 3'b000, 1'b0, 16'h0000, 1'b0);
        br_type = 3'b100; br_target = 16'h0042;
        step("jmp_after_rst", 3'b000, 1'b1, 16'h0042, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
